// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-ported register file with a busy scoreboard.
// Two combinational read ports and two write ports, where port 1 has priority.
// Decode reserves a destination register, which marks it busy.
// Writeback writes the register, which releases it.
// Register 0 always reads as zero and is never busy.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr1_i,
  input  logic [ADDR_WIDTH-1:0] raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o,
  output logic                  rbusy1_o,
  output logic                  rbusy2_o,
  input  logic                  wen0_i,
  input  logic [ADDR_WIDTH-1:0] waddr0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic                  wen1_i,
  input  logic [ADDR_WIDTH-1:0] waddr1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  input  logic                  rsv_en_i,
  input  logic [ADDR_WIDTH-1:0] rsv_addr_i,
  output logic [ADDR_WIDTH:0]   busy_cnt_o
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam int CW   = ADDR_WIDTH + 1;

  // Storage and scoreboard state
  logic [DATA_WIDTH-1:0] mem_q [NREG];
  logic [NREG-1:0]       busy_q;
  logic [NREG-1:0]       busy_d;
  logic [CW-1:0]         busy_cnt_q;
  logic [CW-1:0]         busy_cnt_d;

  // Qualified requests.
  // Address 0 is discarded here.
  // Everything is also held off while reset is asserted, so bypass cannot leak write data.
  logic w0_ok_s;
  logic w1_ok_s;
  logic rsv_ok_s;
  logic w0_shadowed_s;
  logic [NREG-1:0] clr_mask_s;
  logic [NREG-1:0] set_mask_s;

  // One-hot decode of a register address
  function automatic logic [NREG-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
    logic [NREG-1:0] v;
    v = {{(NREG-1){1'b0}}, 1'b1};
    return v << a;
  endfunction

  // Population count of the busy vector
  function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
    logic [CW-1:0] c;
    c = {CW{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      c = c + {{(CW-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Read-port value.
  // With BYPASS set, a write in the current cycle is forwarded and port 1 wins.
  // Without BYPASS, the stored contents are returned.
  function automatic logic [DATA_WIDTH-1:0] read_value(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    if (a == {ADDR_WIDTH{1'b0}}) begin
      v = {DATA_WIDTH{1'b0}};
    end else if (BYPASS && w1_ok_s && (waddr1_i == a)) begin
      v = wdata1_i;
    end else if (BYPASS && w0_ok_s && (waddr0_i == a)) begin
      v = wdata0_i;
    end else begin
      v = mem_q[a];
    end
    return v;
  endfunction

  // Busy indication for a read port.
  // A write forwarded in this cycle makes the data valid, so the port reports not busy.
  function automatic logic read_busy(input logic [ADDR_WIDTH-1:0] a);
    logic hit;
    hit = (w1_ok_s && (waddr1_i == a)) || (w0_ok_s && (waddr0_i == a));
    return busy_q[a] && (a != {ADDR_WIDTH{1'b0}}) && !(BYPASS && hit);
  endfunction

  // Qualify write and reserve requests
  always_comb begin
    w0_ok_s       = wen0_i && (waddr0_i != {ADDR_WIDTH{1'b0}}) && !rst;
    w1_ok_s       = wen1_i && (waddr1_i != {ADDR_WIDTH{1'b0}}) && !rst;
    rsv_ok_s      = rsv_en_i && (rsv_addr_i != {ADDR_WIDTH{1'b0}}) && !rst;
    // Port 0 loses a same-address collision, so only port 1's data lands
    w0_shadowed_s = w1_ok_s && (waddr0_i == waddr1_i);
  end

  // Next busy vector.
  // Writes release their targets, then a reservation sets its target.
  // A reservation therefore wins a same-cycle clash with a write, because the new producer supersedes the old one.
  always_comb begin
    clr_mask_s = (w0_ok_s ? onehot(waddr0_i) : {NREG{1'b0}}) |
                 (w1_ok_s ? onehot(waddr1_i) : {NREG{1'b0}});
    set_mask_s = rsv_ok_s ? onehot(rsv_addr_i) : {NREG{1'b0}};
    busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~{{(NREG-1){1'b0}}, 1'b1};
    busy_cnt_d = popcount(busy_d);
  end

  // Register storage.
  // The reset clears every entry; entry 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (w0_ok_s && !w0_shadowed_s) begin
        mem_q[waddr0_i] <= wdata0_i;
      end
      if (w1_ok_s) begin
        mem_q[waddr1_i] <= wdata1_i;
      end
    end
  end

  // Scoreboard bits and their registered population count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= {NREG{1'b0}};
      busy_cnt_q <= {CW{1'b0}};
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Combinational read ports
  always_comb begin
    rdata1_o   = read_value(raddr1_i);
    rdata2_o   = read_value(raddr2_i);
    rbusy1_o   = read_busy(raddr1_i);
    rbusy2_o   = read_busy(raddr2_i);
    busy_cnt_o = busy_cnt_q;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed bench for reg_file_sb.
// It drives a bypassing instance and a non-bypassing instance with the same inputs.
// A behavioural model is compared against both instances on every negative clock edge.
// Literal expectations pin the key scenarios.
module tb_reg_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] raddr1, raddr2, waddr0, waddr1, rsv_addr;
  logic [DW-1:0] wdata0, wdata1;
  logic          wen0, wen1, rsv_en;

  logic [DW-1:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic          b_rb1, b_rb2, n_rb1, n_rb2;
  logic [AW:0]   b_cnt, n_cnt;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Model state: register contents and busy flags
  logic [DW-1:0] mem_m [NR];
  bit            busy_m [NR];

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst),
    .raddr1_i(raddr1), .raddr2_i(raddr2),
    .rdata1_o(b_rd1), .rdata2_o(b_rd2), .rbusy1_o(b_rb1), .rbusy2_o(b_rb2),
    .wen0_i(wen0), .waddr0_i(waddr0), .wdata0_i(wdata0),
    .wen1_i(wen1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .busy_cnt_o(b_cnt)
  );

  reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst(rst),
    .raddr1_i(raddr1), .raddr2_i(raddr2),
    .rdata1_o(n_rd1), .rdata2_o(n_rd2), .rbusy1_o(n_rb1), .rbusy2_o(n_rb2),
    .wen0_i(wen0), .waddr0_i(waddr0), .wdata0_i(wdata0),
    .wen1_i(wen1), .waddr1_i(waddr1), .wdata1_i(wdata1),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .busy_cnt_o(n_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: apply the write and reserve rules at each clock edge; clear on reset.
  // Port 1 is assigned after port 0, so port 1 wins a collision.
  // The reserve is assigned after the releases, so the reserve wins.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        mem_m[i]  <= '0;
        busy_m[i] <= 1'b0;
      end
    end else begin
      if (wen0 && waddr0 != 0) begin
        mem_m[waddr0]  <= wdata0;
        busy_m[waddr0] <= 1'b0;
      end
      if (wen1 && waddr1 != 0) begin
        mem_m[waddr1]  <= wdata1;
        busy_m[waddr1] <= 1'b0;
      end
      if (rsv_en && rsv_addr != 0) busy_m[rsv_addr] <= 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_rd(input bit byp, input logic [AW-1:0] a);
    if (rst || a == 0) return '0;
    if (byp && wen1 && waddr1 == a) return wdata1;
    if (byp && wen0 && waddr0 == a) return wdata0;
    return mem_m[a];
  endfunction

  function automatic logic exp_rb(input bit byp, input logic [AW-1:0] a);
    bit hit;
    hit = (wen1 && waddr1 == a) || (wen0 && waddr0 == a);
    if (rst || a == 0) return 1'b0;
    return busy_m[a] && !(byp && hit);
  endfunction

  function automatic logic [AW:0] exp_cnt();
    int c = 0;
    for (int i = 1; i < NR; i++) c += int'(busy_m[i]);
    return c[AW:0];
  endfunction

  // Compare both instances against the model on every negative edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("byp_rdata1", b_rd1, exp_rd(1'b1, raddr1));
      chk("byp_rdata2", b_rd2, exp_rd(1'b1, raddr2));
      chk("byp_rbusy1", b_rb1, exp_rb(1'b1, raddr1));
      chk("byp_rbusy2", b_rb2, exp_rb(1'b1, raddr2));
      chk("byp_cnt",    b_cnt, exp_cnt());
      chk("nob_rdata1", n_rd1, exp_rd(1'b0, raddr1));
      chk("nob_rdata2", n_rd2, exp_rd(1'b0, raddr2));
      chk("nob_rbusy1", n_rb1, exp_rb(1'b0, raddr1));
      chk("nob_rbusy2", n_rb2, exp_rb(1'b0, raddr2));
      chk("nob_cnt",    n_cnt, exp_cnt());
    end
  end

  task automatic idle();
    wen0 = 1'b0; waddr0 = '0; wdata0 = '0;
    wen1 = 1'b0; waddr1 = '0; wdata1 = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    raddr1 = '0; raddr2 = '0;
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cmp_en = 1'b1;
    step(); step();
    @(negedge clk);
    chk("reset_cnt", b_cnt, 6'd0);
    step();
    rst = 1'b0;

    // Asynchronous reset pulse between edges wipes r5 and the scoreboard
    wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; rsv_en = 1'b1; rsv_addr = 5'd6;
    step();
    idle(); raddr1 = 5'd5; raddr2 = 5'd6;
    @(negedge clk);
    chk("r5_written", n_rd1, 32'hDEADBEEF);
    chk("r6_busy", n_rb2, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rd_byp", b_rd1, 32'h0);
    chk("async_rst_rd_nob", n_rd1, 32'h0);
    chk("async_rst_cnt", b_cnt, 6'd0);
    #1 rst = 1'b0;
    step();

    // Register 0 ignores writes and reservations
    wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF; rsv_en = 1'b1; rsv_addr = 5'd0;
    @(negedge clk);
    chk("r0_rdata", b_rd1, 32'h0);
    chk("r0_rbusy", b_rb1, 1'b0);
    step();
    idle();
    @(negedge clk);
    chk("r0_cnt", b_cnt, 6'd0);
    chk("r0_after", n_rd1, 32'h0);

    // Bypass and write collision on r7
    step();
    wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h33;
    step();
    wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22; raddr1 = 5'd7; raddr2 = 5'd7;
    @(negedge clk);
    chk("bypass_same_cycle", b_rd1, 32'h22);
    chk("nobypass_old", n_rd1, 32'h33);
    step();
    idle(); raddr1 = 5'd7;
    @(negedge clk);
    chk("collision_byp", b_rd1, 32'h22);
    chk("collision_nob", n_rd1, 32'h22);

    // Scoreboard lifecycle on r3
    step();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    step();
    idle(); raddr1 = 5'd3;
    @(negedge clk);
    chk("r3_busy", b_rb1, 1'b1);
    chk("r3_cnt1", b_cnt, 6'd1);
    step();
    wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h55; raddr1 = 5'd3;
    @(negedge clk);
    chk("r3_fwd_notbusy", b_rb1, 1'b0);
    chk("r3_nob_busy", n_rb1, 1'b1);
    step();
    idle(); raddr1 = 5'd3;
    @(negedge clk);
    chk("r3_cnt0", b_cnt, 6'd0);
    chk("r3_data", b_rd1, 32'h55);

    // A reserve and a write to the same register in one cycle: the reserve wins
    step();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    step();
    rsv_en = 1'b1; rsv_addr = 5'd9; wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hAB;
    step();
    idle(); raddr1 = 5'd9;
    @(negedge clk);
    chk("clash_busy", n_rb1, 1'b1);
    chk("clash_cnt", b_cnt, 6'd1);
    chk("clash_data", n_rd1, 32'hAB);

    // Reserve every register.
    // r9 is already busy and must not be counted twice.
    for (int a = 1; a < NR; a++) begin
      step();
      idle(); rsv_en = 1'b1; rsv_addr = a[AW-1:0];
    end
    step();
    idle();
    @(negedge clk);
    chk("stress_cnt31", b_cnt, 6'd31);
    step();
    wen0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'h1;
    wen1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h2;
    step();
    idle();
    @(negedge clk);
    chk("stress_cnt29", b_cnt, 6'd29);
    // A collision on r4 releases it only once
    step();
    wen0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h4;
    wen1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h44;
    step();
    idle(); raddr1 = 5'd4;
    @(negedge clk);
    chk("coll_cnt28", b_cnt, 6'd28);
    chk("coll_data", n_rd1, 32'h44);

    // Mixed traffic checked by the model only.
    // Read port 2 sometimes shares read port 1's address.
    for (int i = 0; i < 60; i++) begin
      step();
      wen0 = 1'($urandom_range(1)); waddr0 = AW'($urandom_range(NR - 1)); wdata0 = $urandom;
      wen1 = 1'($urandom_range(1)); waddr1 = AW'($urandom_range(NR - 1)); wdata1 = $urandom;
      rsv_en = 1'($urandom_range(1)); rsv_addr = AW'($urandom_range(NR - 1));
      raddr1 = (i % 3 == 0) ? waddr1 : AW'($urandom_range(NR - 1));
      raddr2 = (i % 2 == 0) ? raddr1 : waddr0;
    end
    step();
    idle();
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
